// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg: shared types and helpers for the RAM port arbiter
//   arb_state_t  arbiter FSM states (IDLE, ACCESS, DONE)
//   OWNER_*      owner encoding used by arbitration
//   cnt_width    wait-counter width for a given wait-state count
package ram_port_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t;
    localparam logic OWNER_FETCH = 1'b0;
    localparam logic OWNER_DATA  = 1'b1;
    function automatic int cnt_width(input int w);
        return (w < 1) ? 1 : $clog2(w + 1);
    endfunction
endpackage

// File: rtl/ram_port_arbiter_mem_wait_timer.sv
// mem_wait_timer: loadable down-counter for RAM wait states
//   clk, Reset_n  clock, async active-low reset
//   load, value   load counter with value
//   dec           decrement while non-zero
//   zero          counter is zero
module mem_wait_timer #(
    parameter int CW = 1
) (
    input  logic          clk,
    input  logic          Reset_n,
    input  logic          load,
    input  logic          dec,
    input  logic [CW-1:0] value,
    output logic          zero
);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge Reset_n)
        if (!Reset_n) cnt <= '0;
        else if (load) cnt <= value;
        else if (dec && cnt != '0) cnt <= cnt - CW'(1);
    assign zero = (cnt == '0);
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port RAM between fetch and load/store paths
//   fetch port : f_req, f_addr -> f_gnt, f_done
//   data port  : d_req, d_we, d_addr, d_wdata -> d_gnt, d_done
//   RAM side   : ram_addr, ram_wdata, ReadRAM, WriteRAM <- ram_rdata
//   rdata      : last completed read, busy: FSM not idle
//   ARB_RR_EN  : alternate owner on contested requests (default: data wins)
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 32,
    parameter int MEM_WAIT = 1
) (
    input  logic              clk,
    input  logic              Reset_n,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              ReadRAM,
    output logic              WriteRAM,
    output logic              busy
);
    localparam int CW = cnt_width(MEM_WAIT);
    arb_state_t state;
    logic pick, sel_we, zero;
`ifdef ARB_RR_EN
    logic last_owner;
    assign pick = d_req & (!f_req | last_owner == OWNER_FETCH);
`else
    assign pick = d_req;
`endif
    assign sel_we = pick & d_we;
    mem_wait_timer #(.CW(CW)) u_timer (
        .clk    (clk),
        .Reset_n(Reset_n),
        .load   (state == IDLE && (f_req || d_req)),
        .dec    (state == ACCESS),
        .value  (CW'(MEM_WAIT)),
        .zero   (zero)
    );
    // WriteRAM stays high for the whole ACCESS state, so it doubles as the latched we
    always_ff @(posedge clk or negedge Reset_n)
        if (!Reset_n) begin
            state     <= IDLE;
            f_gnt     <= 1'b0;
            d_gnt     <= 1'b0;
            f_done    <= 1'b0;
            d_done    <= 1'b0;
            rdata     <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ReadRAM   <= 1'b0;
            WriteRAM  <= 1'b0;
            busy      <= 1'b0;
`ifdef ARB_RR_EN
            last_owner <= OWNER_DATA;
`endif
        end else
            case (state)
                IDLE:
                    if (f_req || d_req) begin
                        state     <= ACCESS;
                        busy      <= 1'b1;
                        f_gnt     <= pick == OWNER_FETCH;
                        d_gnt     <= pick == OWNER_DATA;
                        ReadRAM   <= !sel_we;
                        WriteRAM  <= sel_we;
                        ram_addr  <= pick ? d_addr : f_addr;
                        ram_wdata <= pick ? d_wdata : ram_wdata;
`ifdef ARB_RR_EN
                        last_owner <= pick;
`endif
                    end
                ACCESS:
                    if (zero) begin
                        state    <= DONE;
                        ReadRAM  <= 1'b0;
                        WriteRAM <= 1'b0;
                        f_done   <= f_gnt;
                        d_done   <= d_gnt;
                        rdata    <= WriteRAM ? rdata : ram_rdata;
                    end
                DONE: begin
                    state  <= IDLE;
                    f_gnt  <= 1'b0;
                    d_gnt  <= 1'b0;
                    f_done <= 1'b0;
                    d_done <= 1'b0;
                    busy   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed table-driven bench for ram_port_arbiter
module tb_ram_port_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic        Reset_n;
    logic        f_req, f_gnt, f_done, d_req, d_we, d_gnt, d_done;
    logic [8:0]  f_addr, d_addr, ram_addr;
    logic [31:0] d_wdata, rdata, ram_wdata, ram_rdata;
    logic        ReadRAM, WriteRAM, busy;
    logic        z_f_req, z_f_gnt, z_f_done, z_d_req, z_d_we, z_d_gnt, z_d_done;
    logic [8:0]  z_f_addr, z_d_addr, z_ram_addr;
    logic [31:0] z_d_wdata, z_rdata, z_ram_wdata, z_ram_rdata;
    logic        z_ReadRAM, z_WriteRAM, z_busy;
    int n_cmp = 0;
    int n_err = 0;

    ram_port_arbiter #(.ADDR_W(9), .DATA_W(32), .MEM_WAIT(1)) u_dut (
        .clk(clk), .Reset_n(Reset_n),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_done(f_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done), .rdata(rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .ReadRAM(ReadRAM), .WriteRAM(WriteRAM), .busy(busy)
    );

    ram_port_arbiter #(.ADDR_W(9), .DATA_W(32), .MEM_WAIT(0)) u_z (
        .clk(clk), .Reset_n(Reset_n),
        .f_req(z_f_req), .f_addr(z_f_addr), .f_gnt(z_f_gnt), .f_done(z_f_done),
        .d_req(z_d_req), .d_we(z_d_we), .d_addr(z_d_addr), .d_wdata(z_d_wdata),
        .d_gnt(z_d_gnt), .d_done(z_d_done), .rdata(z_rdata),
        .ram_addr(z_ram_addr), .ram_wdata(z_ram_wdata), .ram_rdata(z_ram_rdata),
        .ReadRAM(z_ReadRAM), .WriteRAM(z_WriteRAM), .busy(z_busy)
    );

    typedef struct {
        logic        is_data;
        logic        we;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [31:0] ram_rd;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t vt[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cyc, strobes, wrong, done_cyc;
        cyc = 0; strobes = 0; wrong = 0; done_cyc = -1;
        @(negedge clk);
        ram_rdata = v.ram_rd;
        if (v.is_data) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            f_req = 1'b1; f_addr = v.addr;
        end
        while (done_cyc < 0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (ReadRAM || WriteRAM) begin
                strobes++;
                if ((ReadRAM && WriteRAM) || WriteRAM !== v.we || ram_addr !== v.addr ||
                    (v.we && ram_wdata !== v.wdata) || f_gnt !== !v.is_data || d_gnt !== v.is_data)
                    wrong++;
            end
            if (v.is_data ? f_done : d_done) wrong++;
            if (v.is_data ? d_done : f_done) begin
                done_cyc = cyc;
                chk($sformatf("v%0d_rdata", idx), rdata, v.exp_rdata);
                f_req = 1'b0;
                d_req = 1'b0;
            end
        end
        chk($sformatf("v%0d_done_cycle", idx), 32'(done_cyc), 32'd3);
        chk($sformatf("v%0d_strobe_cycles", idx), 32'(strobes), 32'd2);
        chk($sformatf("v%0d_strobe_gnt_errs", idx), 32'(wrong), 32'd0);
        @(negedge clk);
        chk($sformatf("v%0d_idle_busy", idx), 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bad, cyc, nw;
        int w[4];
        int zd[3];
        vt[0] = '{1'b0, 1'b0, 9'h010, 32'h0,        32'h1A2B3C4D, 32'h1A2B3C4D};
        vt[1] = '{1'b1, 1'b1, 9'h0FF, 32'hDEADBEEF, 32'h55555555, 32'h1A2B3C4D};
        vt[2] = '{1'b1, 1'b0, 9'h123, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D};
        vt[3] = '{1'b0, 1'b0, 9'h1FF, 32'h0,        32'h00000001, 32'h00000001};
        vt[4] = '{1'b1, 1'b1, 9'h000, 32'h12345678, 32'hFFFFFFFF, 32'h00000001};
        f_req = 0; f_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; ram_rdata = 0;
        z_f_req = 0; z_f_addr = 0; z_d_req = 0; z_d_we = 0; z_d_addr = 0; z_d_wdata = 0;
        z_ram_rdata = 0;
        Reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_ctrl", {25'd0, busy, ReadRAM, WriteRAM, f_gnt, d_gnt, f_done, d_done}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_ram_addr", 32'(ram_addr), 32'd0);
        chk("reset_ram_wdata", ram_wdata, 32'd0);
        Reset_n = 1'b1;

        // reset mid-ACCESS of a store
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 9'h0FF; d_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("abort_write_active", 32'(WriteRAM), 32'd1);
        #2 Reset_n = 1'b0;
        #1;
        chk("abort_write_drop", 32'(WriteRAM), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        Reset_n = 1'b1;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (d_done || busy) bad++;
        end
        chk("abort_no_done", 32'(bad), 32'd0);

        for (int i = 0; i < 5; i++) run_vec(vt[i], i);

        // simultaneous requests held for four accesses, fresh reset first
        @(negedge clk); Reset_n = 1'b0;
        @(negedge clk); Reset_n = 1'b1;
        f_req = 1'b1; f_addr = 9'h020; d_req = 1'b1; d_we = 1'b0; d_addr = 9'h040;
        ram_rdata = 32'h0BADCAFE;
        w = '{9, 9, 9, 9};
        nw = 0; bad = 0; cyc = 0;
        while (nw < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if ((f_gnt && d_gnt) || (ReadRAM && WriteRAM)) bad++;
            if (f_done) w[nw++] = 0;
            else if (d_done) w[nw++] = 1;
        end
        f_req = 1'b0; d_req = 1'b0;
        for (int k = 0; k < 4; k++)
`ifdef ARB_RR_EN
            chk($sformatf("contest_%0d_owner", k), 32'(w[k]), 32'(k % 2));
`else
            chk($sformatf("contest_%0d_owner", k), 32'(w[k]), 32'd1);
`endif
        chk("contest_exclusive", 32'(bad), 32'd0);
        @(negedge clk);

        // address change mid-access, request held after done
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 9'h0AA; ram_rdata = 32'h600DF00D;
        @(negedge clk);
        chk("hold_addr_access", 32'(ram_addr), 32'h0AA);
        d_addr = 9'h155;
        bad = 0; cyc = 0;
        while (!d_done && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (ram_addr !== 9'h0AA) bad++;
        end
        chk("hold_addr_stable", 32'(bad), 32'd0);
        chk("hold_done_seen", 32'(d_done), 32'd1);
        chk("hold_rdata", rdata, 32'h600DF00D);
        @(negedge clk);
        chk("rereq_idle_gap", 32'(busy), 32'd0);
        @(negedge clk);
        chk("rereq_started", {30'd0, busy, ReadRAM}, 32'd3);
        chk("rereq_new_addr", 32'(ram_addr), 32'h155);
        d_req = 1'b0;
        cyc = 0;
        while (!d_done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("rereq_done_seen", 32'(d_done), 32'd1);
        @(negedge clk);

        // MEM_WAIT=0: single-cycle ACCESS, accesses every 3 cycles
        @(negedge clk);
        z_f_req = 1'b1; z_f_addr = 9'h033; z_ram_rdata = 32'h77778888;
        zd = '{-100, -100, -100};
        nw = 0; bad = 0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (z_ReadRAM) bad++;
            if (z_f_done && nw < 3) zd[nw++] = c;
        end
        z_f_req = 1'b0;
        chk("mw0_first_done", 32'(zd[0]), 32'd2);
        chk("mw0_gap1", 32'(zd[1] - zd[0]), 32'd3);
        chk("mw0_gap2", 32'(zd[2] - zd[1]), 32'd3);
        chk("mw0_read_cycles", 32'(bad), 32'd3);
        chk("mw0_rdata", z_rdata, 32'h77778888);
        chk("mw0_ram_addr", 32'(z_ram_addr), 32'h033);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
